// File: rtl/reg4_op_arbiter.sv
// Round-robin controller sharing one 4-bit mode-select register between two requesters.
// Latency: grant edge -> ISSUE -> SETTLE -> ACK, so ack is high in the third cycle after the grant edge.
// Backpressure: requesters hold req/op/data until ack; a new grant is taken only from IDLE.
// Optional feature macro: REG4_ARB_OPCNT_EN adds a saturating 8-bit op_count output.
module reg4_op_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] data0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [1:0]       reg_sel,
  output logic [WIDTH-1:0] reg_i,
`ifdef REG4_ARB_OPCNT_EN
  output logic [7:0]       op_count,
`endif
  input  logic [WIDTH-1:0] reg_a
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t state;
  logic   ptr;   // last requester granted; starts at 1 so requester 0 wins the first tie
  logic   gnt;   // requester owning the in-flight operation
  logic   win;   // requester that would be granted at the next IDLE edge

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~ptr;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

  // Operation sequencer; all outputs are registered here so the register sees clean one-cycle drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      gnt     <= 1'b0;
      ack     <= 2'b00;
      rdata   <= '0;
      busy    <= 1'b0;
      reg_sel <= 2'b00;
      reg_i   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack     <= 2'b00;
          reg_sel <= 2'b00;
          reg_i   <= '0;
          if (|req) begin
            gnt     <= win;
            ptr     <= win;
            // The issued sel/I registers double as the latched op/data, so later input changes are ignored
            reg_sel <= win ? op1 : op0;
            reg_i   <= win ? data1 : data0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // The register performs the operation on this edge; stop driving it right away
          reg_sel <= 2'b00;
          reg_i   <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          // Register output now reflects the completed operation
          rdata <= reg_a;
          ack   <= gnt ? 2'b10 : 2'b01;
          state <= ACK;
        end
        ACK: begin
          ack   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack     <= 2'b00;
          busy    <= 1'b0;
          reg_sel <= 2'b00;
          reg_i   <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef REG4_ARB_OPCNT_EN
  // Count completed operations, saturating at 255 instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 8'd0;
    end else if (state == ACK && op_count != 8'hFF) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule
